pulse_load: RTL and testbench

PULSE_LOAD -- requirements
Module: pulse_load

---
 rtl/pulse_load_if.sv | 27 ++
 rtl/pulse_load.sv | 140 ++++++++++++++
 tb/tb_pulse_load.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_load_if.sv
// Load-burst bus between the pulse loader and its controller:
// burst control, 32-bit load-word stream, pulse-memory write port and status.
interface pulse_load_if;
   logic         start;
   logic [4:0]   start_idx;
   logic [5:0]   n_entries;
   logic         abort;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         mem_we;
   logic [4:0]   mem_waddr;
   logic [255:0] mem_wdata;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output start, start_idx, n_entries, abort, s_valid, s_data,
      input  s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err
   );

   modport slave (
      input  start, start_idx, n_entries, abort, s_valid, s_data,
      output s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/pulse_load.sv
// Assembles eight 32-bit load words into 256-bit pulse instructions and writes them to pulse memory.
// Optional PULSE_LOAD_CHECK_EN: drop malformed entries (reserved bits set or t_len==0) and flag err.
module pulse_load (
   input  logic        clk,
   input  logic        rst_n,
   pulse_load_if.slave bus_io
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [4:0]     idx_q, idx_d;
   logic [5:0]     rem_q, rem_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [223:0]   asm_q, asm_d;
   logic [255:0]   wdata_q, wdata_d;
   logic           err_q, err_d;
   logic           we_s;

`ifdef PULSE_LOAD_CHECK_EN
   function automatic logic entry_bad(input logic [255:0] e);
      return (|e[63:62]) || (|e[255:120]) || (e[103:88] == 16'd0);
   endfunction
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         rem_q   <= 6'd0;
         cnt_q   <= 3'd0;
         asm_q   <= 224'd0;
         wdata_q <= 256'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state, datapath and write-strobe logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      we_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               err_d = 1'b0;
               if (bus_io.n_entries != 6'd0) begin
                  idx_d   = bus_io.start_idx;
                  rem_d   = bus_io.n_entries;
                  cnt_d   = 3'd0;
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            // The eighth word goes straight into the output register so mem_wdata
            // only changes when a complete entry exists.
            if (bus_io.abort) begin
               err_d   = 1'b1;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else if (bus_io.s_valid) begin
               if (cnt_q == 3'd7) begin
                  wdata_d = {bus_io.s_data, asm_q};
                  state_d = WRITE;
               end else begin
                  asm_d[{cnt_q, 5'd0} +: 32] = bus_io.s_data;
                  cnt_d                      = cnt_q + 3'd1;
               end
            end else begin
               state_d = LOAD;
            end
         end
         WRITE: begin
            if (bus_io.abort) begin
               err_d   = 1'b1;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
`ifdef PULSE_LOAD_CHECK_EN
               if (entry_bad(wdata_q)) begin
                  we_s  = 1'b0;
                  err_d = 1'b1;
               end else begin
                  we_s = 1'b1;
               end
`else
               we_s = 1'b1;
`endif
               idx_d = idx_q + 5'd1;
               rem_d = rem_q - 6'd1;
               cnt_d = 3'd0;
               if (rem_q == 6'd1) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus_io.s_ready   = (state_q == LOAD);
   assign bus_io.busy      = (state_q != IDLE);
   assign bus_io.done      = (state_q == DONE);
   assign bus_io.err       = err_q;
   assign bus_io.mem_we    = we_s;
   assign bus_io.mem_waddr = idx_q;
   assign bus_io.mem_wdata = wdata_q;

endmodule

// File: tb/tb_pulse_load.sv
// Directed self-checking bench for pulse_load: reset, single entry, wrap, throttled
// stream, abort, empty burst, reset mid-burst and entry checking.
module tb_pulse_load;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pulse_load_if bus ();

   pulse_load dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int done_n = 0;
   int done_cyc = 0;
   int rdy_n  = 0;
   logic [4:0]   we_addr[$];
   logic [255:0] we_data[$];
   int           we_cyc[$];

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         we_addr.push_back(bus.mem_waddr);
         we_data.push_back(bus.mem_wdata);
         we_cyc.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
      end
      if (bus.s_ready === 1'b1) rdy_n <= rdy_n + 1;
   end

   function automatic logic [255:0] make_ent(input int e);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = {8'hC0, 8'(e), 8'(k), 8'h5A};
      return r;
   endfunction

   task automatic clear_log();
      @(posedge clk);
      #1;
      we_addr.delete();
      we_data.delete();
      we_cyc.delete();
      done_n = 0;
      rdy_n  = 0;
   endtask

   task automatic do_start(input logic [4:0] idx, input logic [5:0] n);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.start_idx = idx;
      bus.n_entries = n;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic send_entry(input logic [255:0] ent, input int nwords, input bit toggle);
      int k = 0;
      int guard = 0;
      bit gap = 1'b0;
      while (k < nwords && guard < 200) begin
         @(negedge clk);
         guard++;
         if (toggle && gap) begin
            bus.s_valid = 1'b0;
         end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = ent[32*k +: 32];
            if (bus.s_ready === 1'b1) k++;
         end
         gap = !gap;
      end
      if (k < nwords) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: accepted %0d words, required %0d", k, nwords);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (bus.busy === 1'b1 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_timeout: busy=%b required 0", bus.busy); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      n_cmp++; if (bus.mem_waddr !== 5'd0) begin n_err++; $display("FAIL rst_waddr: got %h want 0", bus.mem_waddr); end
      n_cmp++; if (bus.mem_wdata !== 256'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [255:0] ent;
      for (int k = 0; k < 8; k++) ent[32*k +: 32] = 32'h11111111 * (k + 1);
      clear_log();
      do_start(5'd3, 6'd1);
      send_entry(ent, 8, 1'b0);
      bus.s_valid = 1'b0;
      wait_idle();
      n_cmp++; if (we_addr.size() != 1) begin n_err++; $display("FAIL single_we_count: got %0d want 1", we_addr.size()); end
      if (we_addr.size() == 1) begin
         n_cmp++; if (we_addr[0] !== 5'd3) begin n_err++; $display("FAIL single_addr: got %0d want 3", we_addr[0]); end
         n_cmp++; if (we_data[0][31:0] !== 32'h11111111) begin n_err++; $display("FAIL single_w0: got %h want 11111111", we_data[0][31:0]); end
         n_cmp++; if (we_data[0][255:224] !== 32'h88888888) begin n_err++; $display("FAIL single_w7: got %h want 88888888", we_data[0][255:224]); end
         n_cmp++; if (we_data[0] !== ent) begin n_err++; $display("FAIL single_data: got %h want %h", we_data[0], ent); end
         n_cmp++; if (done_cyc - we_cyc[0] != 1) begin n_err++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - we_cyc[0]); end
      end
      n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", done_n); end
      n_cmp++; if (bus.mem_wdata !== ent) begin n_err++; $display("FAIL single_wdata_hold: got %h want %h", bus.mem_wdata, ent); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", bus.err); end
   endtask

   task automatic test_wrap();
      logic [4:0] exp_a [3];
      exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0;
      clear_log();
      do_start(5'd30, 6'd3);
      for (int e = 0; e < 3; e++) send_entry(make_ent(e), 8, 1'b0);
      bus.s_valid = 1'b0;
      wait_idle();
      n_cmp++; if (we_addr.size() != 3) begin n_err++; $display("FAIL wrap_we_count: got %0d want 3", we_addr.size()); end
      if (we_addr.size() == 3) begin
         for (int e = 0; e < 3; e++) begin
            n_cmp++; if (we_addr[e] !== exp_a[e]) begin n_err++; $display("FAIL wrap_addr%0d: got %0d want %0d", e, we_addr[e], exp_a[e]); end
            n_cmp++; if (we_data[e] !== make_ent(e)) begin n_err++; $display("FAIL wrap_data%0d: got %h want %h", e, we_data[e], make_ent(e)); end
         end
         n_cmp++; if (we_cyc[1] - we_cyc[0] != 9) begin n_err++; $display("FAIL wrap_gap01: got %0d want 9", we_cyc[1] - we_cyc[0]); end
         n_cmp++; if (we_cyc[2] - we_cyc[1] != 9) begin n_err++; $display("FAIL wrap_gap12: got %0d want 9", we_cyc[2] - we_cyc[1]); end
      end
      n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL wrap_done_count: got %0d want 1", done_n); end
   endtask

   task automatic test_toggle();
      clear_log();
      do_start(5'd7, 6'd1);
      // A second start while busy must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.start_idx = 5'd20; bus.n_entries = 6'd5;
      @(negedge clk);
      bus.start = 1'b0;
      send_entry(make_ent(9), 8, 1'b1);
      bus.s_valid = 1'b0;
      wait_idle();
      n_cmp++; if (we_addr.size() != 1) begin n_err++; $display("FAIL toggle_we_count: got %0d want 1", we_addr.size()); end
      if (we_addr.size() == 1) begin
         n_cmp++; if (we_addr[0] !== 5'd7) begin n_err++; $display("FAIL toggle_addr: got %0d want 7", we_addr[0]); end
         n_cmp++; if (we_data[0] !== make_ent(9)) begin n_err++; $display("FAIL toggle_data: got %h want %h", we_data[0], make_ent(9)); end
      end
      n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL toggle_done_count: got %0d want 1", done_n); end
   endtask

   task automatic test_abort();
      clear_log();
      do_start(5'd5, 6'd2);
      send_entry(make_ent(4), 5, 1'b0);
      @(negedge clk);
      bus.abort   = 1'b1;
      bus.s_valid = 1'b1;
      @(negedge clk);
      bus.abort   = 1'b0;
      bus.s_valid = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL abort_err: got %b want 1", bus.err); end
      repeat (4) @(negedge clk);
      n_cmp++; if (we_addr.size() != 0) begin n_err++; $display("FAIL abort_we_count: got %0d want 0", we_addr.size()); end
      n_cmp++; if (done_n != 0) begin n_err++; $display("FAIL abort_done_count: got %0d want 0", done_n); end
      do_start(5'd9, 6'd1);
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL abort_err_clear: got %b want 0", bus.err); end
      send_entry(make_ent(6), 8, 1'b0);
      bus.s_valid = 1'b0;
      wait_idle();
      n_cmp++; if (we_addr.size() != 1) begin n_err++; $display("FAIL abort_next_count: got %0d want 1", we_addr.size()); end
      if (we_addr.size() == 1) begin
         n_cmp++; if (we_data[0] !== make_ent(6)) begin n_err++; $display("FAIL abort_next_data: got %h want %h", we_data[0], make_ent(6)); end
      end
   endtask

   task automatic test_empty();
      clear_log();
      do_start(5'd4, 6'd0);
      n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %b want 1", bus.done); end
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL empty_done_count: got %0d want 1", done_n); end
      n_cmp++; if (rdy_n != 0) begin n_err++; $display("FAIL empty_ready: got %0d want 0", rdy_n); end
      n_cmp++; if (we_addr.size() != 0) begin n_err++; $display("FAIL empty_we_count: got %0d want 0", we_addr.size()); end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL idle_abort_err: got %b want 0", bus.err); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_abort_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      do_start(5'd2, 6'd1);
      send_entry(make_ent(3), 3, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.mem_wdata !== 256'd0) begin n_err++; $display("FAIL rstmid_wdata: got %h want 0", bus.mem_wdata); end
      rst_n = 1'b1;
      clear_log();
      repeat (20) @(negedge clk);
      bus.s_valid = 1'b0;
      n_cmp++; if (we_addr.size() != 0) begin n_err++; $display("FAIL rstmid_we_count: got %0d want 0", we_addr.size()); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", bus.busy); end
   endtask

   task automatic test_check();
      logic [255:0] bad_e;
      logic [255:0] good_e;
      bad_e  = 256'd0;
      good_e = 256'd0;
      bad_e[31:0]   = 32'h1; bad_e[63:32]  = 32'h2; bad_e[95:64]  = 32'h3;
      good_e[31:0]  = 32'h1; good_e[63:32] = 32'h2; good_e[95:64] = 32'h0100_0003; good_e[127:96] = 32'h1;
      clear_log();
      do_start(5'd10, 6'd2);
      send_entry(bad_e, 8, 1'b0);
      send_entry(good_e, 8, 1'b0);
      bus.s_valid = 1'b0;
      wait_idle();
      n_cmp++; if (done_n != 1) begin n_err++; $display("FAIL check_done_count: got %0d want 1", done_n); end
`ifdef PULSE_LOAD_CHECK_EN
      n_cmp++; if (we_addr.size() != 1) begin n_err++; $display("FAIL check_we_count: got %0d want 1", we_addr.size()); end
      if (we_addr.size() == 1) begin
         n_cmp++; if (we_addr[0] !== 5'd11) begin n_err++; $display("FAIL check_addr: got %0d want 11", we_addr[0]); end
         n_cmp++; if (we_data[0] !== good_e) begin n_err++; $display("FAIL check_data: got %h want %h", we_data[0], good_e); end
      end
      n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL check_err: got %b want 1", bus.err); end
`else
      n_cmp++; if (we_addr.size() != 2) begin n_err++; $display("FAIL check_we_count: got %0d want 2", we_addr.size()); end
      if (we_addr.size() == 2) begin
         n_cmp++; if (we_addr[0] !== 5'd10) begin n_err++; $display("FAIL check_addr0: got %0d want 10", we_addr[0]); end
         n_cmp++; if (we_data[0] !== bad_e) begin n_err++; $display("FAIL check_data0: got %h want %h", we_data[0], bad_e); end
         n_cmp++; if (we_addr[1] !== 5'd11) begin n_err++; $display("FAIL check_addr1: got %0d want 11", we_addr[1]); end
      end
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL check_err: got %b want 0", bus.err); end
`endif
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.start_idx = 5'd0;
      bus.n_entries = 6'd0;
      bus.abort     = 1'b0;
      bus.s_valid   = 1'b0;
      bus.s_data    = 32'd0;
      test_reset();
      test_single();
      test_wrap();
      test_toggle();
      test_abort();
      test_empty();
      test_reset_mid();
      test_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
